// File: rtl/micro_sequencer.sv
// Microprogram address sequencer: condition select, next-address mux, loop counter and return stack.
// The return stack is only built when SEQ_STACK_EN is defined; otherwise CALL/RET degrade to JCOND/CONT.
module micro_sequencer #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [3:0]    P,
    input  logic [1:0]    SEL,
    input  logic          POL,
    input  logic [2:0]    OP,
    input  logic [AW-1:0] BA,
    output logic [AW-1:0] MA,
    output logic          COND,
    output logic          HALTED,
    output logic          SP_FULL,
    output logic          SP_EMPTY,
    output logic          ERR
);

    typedef enum logic [2:0] {
        OP_CONT  = 3'd0,
        OP_JMP   = 3'd1,
        OP_JCOND = 3'd2,
        OP_CALL  = 3'd3,
        OP_RET   = 3'd4,
        OP_LDCNT = 3'd5,
        OP_LOOP  = 3'd6,
        OP_HALT  = 3'd7
    } op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // EN is a pure advance strobe with no backpressure: every rising edge with EN=1 in ST_RUN
    // consumes exactly one microinstruction (OP/BA/SEL/POL); with EN=0 all state holds.
    state_e        r_state, w_state_d;
    logic [AW-1:0] r_ma, w_ma_d;
    logic [AW-1:0] r_cnt, w_cnt_d;
    logic [AW-1:0] w_ma_inc;
    logic          w_run;
    op_e           w_op;

    assign COND     = P[SEL] ^ POL;
    assign w_ma_inc = r_ma + AW'(1);
    assign w_run    = EN && (r_state == ST_RUN);
    assign w_op     = op_e'(OP);
    assign MA       = r_ma;
    assign HALTED   = (r_state == ST_HALT);

`ifdef SEQ_STACK_EN
    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [AW-1:0]  r_stack [DEPTH];
    logic [SPW-1:0] r_sp, w_sp_d;
    logic           r_err, w_err_d;
    logic           w_push;
    logic [AW-1:0]  w_top;

    assign SP_FULL  = (r_sp == SPW'(DEPTH));
    assign SP_EMPTY = (r_sp == '0);
    assign ERR      = r_err;
    assign w_top    = r_stack[r_sp[IW-1:0] - IW'(1)];
`else
    assign SP_FULL  = 1'b0;
    assign SP_EMPTY = 1'b1;
    assign ERR      = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_ma_d    = r_ma;
        w_cnt_d   = r_cnt;
`ifdef SEQ_STACK_EN
        w_sp_d    = r_sp;
        w_err_d   = r_err;
        w_push    = 1'b0;
`endif
        if (w_run) begin
            case (w_op)
                OP_CONT:  w_ma_d = w_ma_inc;
                OP_JMP:   w_ma_d = BA;
                OP_JCOND: w_ma_d = COND ? BA : w_ma_inc;
                OP_CALL: begin
`ifdef SEQ_STACK_EN
                    w_ma_d = w_ma_inc;
                    if (COND) begin
                        // A full stack refuses the push and falls through to the next address.
                        if (SP_FULL) begin
                            w_err_d = 1'b1;
                        end else begin
                            w_push = 1'b1;
                            w_sp_d = r_sp + SPW'(1);
                            w_ma_d = BA;
                        end
                    end
`else
                    w_ma_d = COND ? BA : w_ma_inc;
`endif
                end
                OP_RET: begin
`ifdef SEQ_STACK_EN
                    if (SP_EMPTY) begin
                        w_err_d = 1'b1;
                        w_ma_d  = w_ma_inc;
                    end else begin
                        w_sp_d = r_sp - SPW'(1);
                        w_ma_d = w_top;
                    end
`else
                    w_ma_d = w_ma_inc;
`endif
                end
                OP_LDCNT: begin
                    w_cnt_d = BA;
                    w_ma_d  = w_ma_inc;
                end
                OP_LOOP: begin
                    if (r_cnt != '0) begin
                        w_cnt_d = r_cnt - AW'(1);
                        w_ma_d  = BA;
                    end else begin
                        w_ma_d = w_ma_inc;
                    end
                end
                OP_HALT:  w_state_d = ST_HALT;
                default:  w_ma_d = w_ma_inc;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_RUN;
            r_ma    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_ma    <= w_ma_d;
            r_cnt   <= w_cnt_d;
        end
    end

`ifdef SEQ_STACK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_sp  <= w_sp_d;
            r_err <= w_err_d;
        end
    end

    // Stack contents need no reset; only r_sp defines which entries are live.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_stack[r_sp[IW-1:0]] <= w_ma_inc;
        end
    end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: driver pushes expected observations, monitor pops and compares.
// Expectations cover both builds (SEQ_STACK_EN defined or not).
module tb_micro_sequencer;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [3:0] P;
    logic [1:0] SEL;
    logic       POL;
    logic [2:0] OP;
    logic [7:0] BA;
    logic [7:0] MA;
    logic       COND;
    logic       HALTED;
    logic       SP_FULL;
    logic       SP_EMPTY;
    logic       ERR;

    micro_sequencer #(.AW(8), .DEPTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .P        (P),
        .SEL      (SEL),
        .POL      (POL),
        .OP       (OP),
        .BA       (BA),
        .MA       (MA),
        .COND     (COND),
        .HALTED   (HALTED),
        .SP_FULL  (SP_FULL),
        .SP_EMPTY (SP_EMPTY),
        .ERR      (ERR)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // scoreboard state: {MA, HALTED, SP_FULL, SP_EMPTY, ERR, COND}
    logic [12:0] exp_q[$];
    string       name_q[$];
    event        chk_ev;
    int          checks = 0;
    int          errors = 0;
    int          n_push = 0;
    logic        e_halted, e_full, e_empty, e_err, e_cond;

    task automatic expect_obs(input string name, input logic [7:0] ema);
        exp_q.push_back({ema, e_halted, e_full, e_empty, e_err, e_cond});
        name_q.push_back(name);
        n_push++;
    endtask

    // Called at a falling edge: drive one microinstruction, expect its result after the next rising edge.
    task automatic step(input string name, input logic [2:0] op, input logic [7:0] ba, input logic [7:0] ema);
        OP = op;
        BA = ba;
        expect_obs(name, ema);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Expectation checked between edges (asynchronous reset response).
    task automatic check_async(input string name, input logic [7:0] ema);
        expect_obs(name, ema);
        -> chk_ev;
        #2;
    endtask

    task automatic reset_expect();
        e_halted = 1'b0;
        e_full   = 1'b0;
        e_empty  = 1'b1;
        e_err    = 1'b0;
    endtask

    // monitor
    initial begin : monitor
        logic [12:0] exp_v;
        logic [12:0] act_v;
        string       nm;
        forever begin
            @(posedge CLK or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {MA, HALTED, SP_FULL, SP_EMPTY, ERR, COND};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got MA=%02h HALTED=%b FULL=%b EMPTY=%b ERR=%b COND=%b, expected MA=%02h HALTED=%b FULL=%b EMPTY=%b ERR=%b COND=%b",
                             nm, act_v[12:5], act_v[4], act_v[3], act_v[2], act_v[1], act_v[0],
                             exp_v[12:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    // watchdog
    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got no end, expected end before 100000ns");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // driver
    initial begin : main
        RST = 1'b1; EN = 1'b0; P = 4'h0; SEL = 2'd0; POL = 1'b0; OP = 3'd0; BA = 8'h00;
        reset_expect();
        e_cond = 1'b0;
        @(negedge CLK);
        check_async("reset", 8'h00);
        @(negedge CLK);
        RST = 1'b0;

        // sequential execution, then hold with EN=0
        EN = 1'b1;
        step("cont1", 3'd0, 8'h00, 8'h01);
        step("cont2", 3'd0, 8'h00, 8'h02);
        step("cont3", 3'd0, 8'h00, 8'h03);
        EN = 1'b0;
        step("hold1", 3'd1, 8'h55, 8'h03);
        step("hold2", 3'd5, 8'h66, 8'h03);
        EN = 1'b1;

        // conditional branch on P[2]
        P = 4'b0100; SEL = 2'd2; POL = 1'b0; e_cond = 1'b1;
        step("jcond_taken", 3'd2, 8'h40, 8'h40);
        POL = 1'b1; e_cond = 1'b0;
        step("jcond_not", 3'd2, 8'h40, 8'h41);
        POL = 1'b0; e_cond = 1'b1;
        step("jmp", 3'd1, 8'h10, 8'h10);

`ifdef SEQ_STACK_EN
        e_empty = 1'b0;
        step("call", 3'd3, 8'h80, 8'h80);
        e_empty = 1'b1;
        step("ret", 3'd4, 8'h00, 8'h11);
        POL = 1'b1; e_cond = 1'b0;
        step("call_not", 3'd3, 8'hA0, 8'h12);
        POL = 1'b0; e_cond = 1'b1;
        step("ov_jmp", 3'd1, 8'h30, 8'h30);
        e_empty = 1'b0;
        step("ov_call1", 3'd3, 8'h50, 8'h50);
        step("ov_call2", 3'd3, 8'h60, 8'h60);
        step("ov_call3", 3'd3, 8'h70, 8'h70);
        e_full = 1'b1;
        step("ov_call4", 3'd3, 8'h78, 8'h78);
        e_err = 1'b1;
        step("ov_call5", 3'd3, 8'h7C, 8'h79);
        e_full = 1'b0;
        step("ov_ret1", 3'd4, 8'h00, 8'h71);
        step("ov_ret2", 3'd4, 8'h00, 8'h61);
        step("ov_ret3", 3'd4, 8'h00, 8'h51);
        e_empty = 1'b1;
        step("ov_ret4", 3'd4, 8'h00, 8'h31);
        step("ov_ret5", 3'd4, 8'h00, 8'h32);
`else
        step("call", 3'd3, 8'h80, 8'h80);
        step("ret", 3'd4, 8'h00, 8'h81);
        POL = 1'b1; e_cond = 1'b0;
        step("call_not", 3'd3, 8'hA0, 8'h82);
        POL = 1'b0; e_cond = 1'b1;
        step("ov_jmp", 3'd1, 8'h30, 8'h30);
        step("ov_call1", 3'd3, 8'h50, 8'h50);
        step("ov_call2", 3'd3, 8'h60, 8'h60);
        step("ov_call3", 3'd3, 8'h70, 8'h70);
        step("ov_call4", 3'd3, 8'h78, 8'h78);
        step("ov_call5", 3'd3, 8'h7C, 8'h7C);
        step("ov_ret1", 3'd4, 8'h00, 8'h7D);
        step("ov_ret2", 3'd4, 8'h00, 8'h7E);
        step("ov_ret3", 3'd4, 8'h00, 8'h7F);
        step("ov_ret4", 3'd4, 8'h00, 8'h80);
        step("ov_ret5", 3'd4, 8'h00, 8'h81);
`endif

        // reset mid-operation, then RET on an empty stack
        RST = 1'b1;
        reset_expect();
        check_async("rst_mid", 8'h00);
        @(negedge CLK);
        RST = 1'b0;
`ifdef SEQ_STACK_EN
        e_err = 1'b1;
`endif
        step("ret_empty", 3'd4, 8'h00, 8'h01);
        RST = 1'b1;
        reset_expect();
        check_async("rst_err", 8'h00);
        @(negedge CLK);
        RST = 1'b0;

        // loop counter (COND false to show LOOP ignores it)
        POL = 1'b1; e_cond = 1'b0;
        step("lp_jmp", 3'd1, 8'h1F, 8'h1F);
        step("ldcnt3", 3'd5, 8'h03, 8'h20);
        step("loop1", 3'd6, 8'h20, 8'h20);
        step("loop2", 3'd6, 8'h20, 8'h20);
        step("loop3", 3'd6, 8'h20, 8'h20);
        step("loop_exit", 3'd6, 8'h20, 8'h21);
        step("ldcnt0", 3'd5, 8'h00, 8'h22);
        step("loop_zero", 3'd6, 8'h20, 8'h23);

        // wrap-around
        step("jmp_ff", 3'd1, 8'hFF, 8'hFF);
        step("wrap", 3'd0, 8'h00, 8'h00);

        // HALT, then async reset between edges
        step("jmp44", 3'd1, 8'h44, 8'h44);
        e_halted = 1'b1;
        step("halt", 3'd7, 8'h00, 8'h44);
        step("halt_h1", 3'd1, 8'h99, 8'h44);
        step("halt_h2", 3'd0, 8'h00, 8'h44);
        EN = 1'b0;
        step("halt_h3", 3'd7, 8'h00, 8'h44);
        EN = 1'b1;
        step("halt_h4", 3'd5, 8'h10, 8'h44);
        RST = 1'b1;
        reset_expect();
        check_async("rst_halt", 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        step("post_rst", 3'd0, 8'h00, 8'h01);

        // scoreboard drained
        checks++;
        if (exp_q.size() != 0 || checks != n_push + 1) begin
            errors++;
            $display("FAIL drain: got %0d pending, %0d compared, expected 0 pending, %0d compared",
                     exp_q.size(), checks - 1, n_push);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram address sequencer for the central unit: the consumer of the 4-bit condition vector P produced by the logic condition unit. Each cycle it selects one bit of P, optionally inverts it, and uses it with a 3-bit opcode from the current microinstruction to form the next microaddress. It provides a subroutine return stack and a loop counter. Its registered microaddress MA drives the control-store read port.

## Interface
Parameters:
- AW, 8, microaddress and loop-counter width
- DEPTH, 4, return-stack entries (power of two, ≥2)

Ports:
- CLK  in  1  clock; everything updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- EN  in  1  advance enable; when 0, all state holds
- P  in  4  condition vector from the logic condition unit
- SEL  in  2  index of the P bit under test
- POL  in  1  1 inverts the tested bit
- OP  in  3  sequencer opcode
- BA  in  AW  branch address / counter load value
- MA  out  AW  current microaddress (registered)
- COND  out  1  combinational P[SEL] ^ POL
- HALTED  out  1  sequencer stopped by HALT
- SP_FULL  out  1  stack holds DEPTH entries
- SP_EMPTY  out  1  stack holds 0 entries
- ERR  out  1  sticky stack over/underflow flag

## Operation
- Reset: MA=0, CNT=0, SP=0, ERR=0, HALTED=0, SP_EMPTY=1, SP_FULL=0. Stack contents are don't-care.
- Opcodes, applied on an edge with EN=1 and HALTED=0. "Next" means MA+1, mod 2^AW, so address 2^AW-1 wraps to 0.
  - 0 CONT: MA ← next.
  - 1 JMP: MA ← BA.
  - 2 JCOND: MA ← COND ? BA : next.
  - 3 CALL: if COND, push next and set MA ← BA; otherwise MA ← next.
  - 4 RET: pop; MA ← popped value.
  - 5 LDCNT: CNT ← BA; MA ← next.
  - 6 LOOP: if CNT≠0, CNT ← CNT-1 and MA ← BA; otherwise MA ← next and CNT stays 0.
  - 7 HALT: MA holds; HALTED ← 1. HALTED clears only on RST.
- CALL with COND=1 and the stack full: no push; MA ← next; ERR ← 1.
- RET with the stack empty: MA ← next; ERR ← 1.
- ERR clears only on RST.
- LOOP ignores COND. The count loaded with N executes the branch N times.

## Timing
- COND is combinational from P, SEL and POL, with no register.
- MA, CNT, SP, ERR and HALTED change only on a rising CLK edge with EN=1, or on RST.
- One microinstruction is consumed per enabled edge, so latency is 1 cycle from OP/BA valid to the new MA.
- P, SEL, POL, OP and BA must be stable for setup before the edge. The bench drives them 1/2 period after the edge.
- SP_FULL and SP_EMPTY are decoded from the registered SP and are valid in the same cycle as SP.
- RST asserted mid-operation clears state immediately, without waiting for a clock edge. After RST deasserts, the first enabled edge executes from MA=0.
- EN=0 during HALT has no effect. HALTED stays 1.

## Configuration
- SEQ_STACK_EN defined:
  - The return stack is built.
  - CALL and RET behave as described in Operation.
- SEQ_STACK_EN undefined:
  - No stack storage is built.
  - CALL behaves as JCOND.
  - RET behaves as CONT.
  - SP_FULL=0 and SP_EMPTY=1, both constant.
  - ERR is constant 0.

## Test plan
- Reset then sequential execution: RST pulse, then OP=0 for 3 enabled edges → MA = 0, 1, 2, 3. Then EN=0 for 2 edges → MA stays 3.
- Conditional branch: P=4'b0100, SEL=2, POL=0, OP=2, BA=8'h40 → COND=1 and MA=8'h40. Repeat with POL=1 → COND=0 and MA=8'h41.
- Call/return (macro defined): at MA=8'h10, OP=3 with COND=1 and BA=8'h80 → MA=8'h80 and SP_EMPTY=0. Then OP=4 → MA=8'h11 and SP_EMPTY=1.
- Stack overflow: DEPTH=4. Five CALLs with COND=1 → the fifth leaves MA=previous+1, SP_FULL=1, ERR=1. A RET on an empty stack also sets ERR.
- Loop and wrap-around:
  - OP=5, BA=3, then OP=6, BA=8'h20 looping on itself → three branches to 8'h20, CNT reaches 0, then MA=8'h21.
  - From MA=8'hFF, OP=0 → MA=8'h00.
- HALT and async reset: OP=7 → MA frozen and HALTED=1 across 4 edges. Asserting RST between edges → MA=0 and HALTED=0 before the next edge.
